// File: rtl/reg_write_queue.sv
// Register writeback queue: buffers producer writes and drains one per cycle into the RF write port.
// Optional decode-stage bypass lookup is enabled by defining RWQ_FWD_EN.
module reg_write_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_addr,
   input  logic [DW-1:0]            in_data,
   input  logic                     drain_hold,
   output logic                     WE,
   output logic [AW-1:0]            W_A,
   output logic [DW-1:0]            WD,
   input  logic [AW-1:0]            R_A1,
   input  logic [AW-1:0]            R_A2,
   output logic                     fwd1_hit,
   output logic [DW-1:0]            fwd1_data,
   output logic                     fwd2_hit,
   output logic [DW-1:0]            fwd2_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [AW-1:0]    r_addr [DEPTH];
   logic [DW-1:0]    r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic w_empty;
   logic w_push;
   logic w_pop;

   assign w_empty  = (r_count == '0);
   assign in_ready = (r_count < CW'(DEPTH));
   // Register 0 writes complete the handshake but never occupy an entry.
   assign w_push   = in_valid && in_ready && (in_addr != '0);
   // Draining is suppressed in the reset cycle so no stale write reaches the RF.
   assign w_pop    = !w_empty && !drain_hold && !rst;

   assign WE    = w_pop;
   assign W_A   = w_pop ? r_addr[r_rd_ptr] : '0;
   assign WD    = w_pop ? r_data[r_rd_ptr] : '0;
   assign count = r_count;
   assign empty = w_empty;

   // Queue storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_valid  <= '0;
      end else begin
         if (w_push) begin
            r_addr[r_wr_ptr]  <= in_addr;
            r_data[r_wr_ptr]  <= in_data;
            r_valid[r_wr_ptr] <= 1'b1;
            r_wr_ptr          <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_valid[r_rd_ptr] <= 1'b0;
            r_rd_ptr          <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef RWQ_FWD_EN
   logic [PW-1:0] w_idx;

   // Scan oldest to youngest so the last match (youngest) wins.
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
      w_idx     = r_rd_ptr;
      for (int k = 0; k < int'(DEPTH); k++) begin
         w_idx = r_rd_ptr + PW'(k);
         if (r_valid[w_idx] && (r_addr[w_idx] == R_A1) && (R_A1 != '0)) begin
            fwd1_hit  = 1'b1;
            fwd1_data = r_data[w_idx];
         end
         if (r_valid[w_idx] && (r_addr[w_idx] == R_A2) && (R_A2 != '0)) begin
            fwd2_hit  = 1'b1;
            fwd2_data = r_data[w_idx];
         end
      end
   end
`else
   logic w_unused;

   assign fwd1_hit  = 1'b0;
   assign fwd1_data = '0;
   assign fwd2_hit  = 1'b0;
   assign fwd2_data = '0;
   assign w_unused  = ^{R_A1, R_A2, r_valid};
`endif

endmodule
